hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- HI/LO result stage that sits directly downstream of the iterative radix-16 Booth multiplier in the MIPS ALU.
- Accepts MULT/MTHI/MTLO/MFHI/MFLO requests from decode and launches the multiplier with latched operands.
- Waits for the 64-bit product, writes it into the HI/LO architectural registers, and stalls the pipeline while a multiply is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO register width; product is 2*DATA_W.
- MAX_WAIT, 128, cycles allowed in WAIT before timeout.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- CLK  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- OpValid  in  1  request valid from decode.
- Op  in  3  operation code: 000 NOP, 001 MULT, 010 MTHI, 011 MTLO, 100 MFHI, 101 MFLO, 110 MADD, 111 MSUB.
- RsData  in  DATA_W  rs operand.
- RtData  in  DATA_W  rt operand.
- MulStart  out  1  one-cycle pulse to start the multiplier.
- MulA  out  DATA_W  latched multiplicand (rs).
- MulB  out  DATA_W  latched multiplier (rt).
- MulDone  in  1  multiplier result-valid pulse.
- MulProduct  in  2*DATA_W  signed product from the multiplier.
- Stall  out  1  hold decode; the request is not accepted this cycle.
- ReadValid  out  1  one-cycle pulse; ReadData is valid.
- ReadData  out  DATA_W  MFHI/MFLO result.
- Hi  out  DATA_W  architectural HI register.
- Lo  out  DATA_W  architectural LO register.
- Error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, active-high): state=IDLE; Hi, Lo, MulA, MulB, ReadData, the product register and the counter all 0; MulStart, ReadValid, Error, Stall all 0. The reset edge takes effect immediately, without waiting for CLK.
- Reset mid-multiply: return to IDLE; a MulDone arriving after reset release is ignored; HI/LO stay 0.
- States: IDLE, WAIT, WB.
- IDLE, request accepted when OpValid=1 and Stall=0:
  - MULT/MADD/MSUB: MulA<=RsData, MulB<=RtData, MulStart=1 on the next cycle only, counter<=0, op kind latched, ->WAIT.
  - MTHI: Hi<=RsData at that edge. MTLO: Lo<=RsData at that edge. State stays IDLE.
  - MFHI/MFLO: ReadData<=Hi or Lo, ReadValid=1 the following cycle. Latency is 1 cycle.
  - NOP, or OpValid=0: no effect.
- WAIT:
  - Counter increments every cycle.
  - MulDone=1: product register<=MulProduct, ->WB.
  - Counter reaching MAX_WAIT with no MulDone: Error<=1 (sticky until Reset), ->IDLE, HI/LO unchanged.
- WB, one cycle:
  - MULT: {Hi,Lo}<={product}.
  - MADD: {Hi,Lo}<={Hi,Lo}+product.
  - MSUB: {Hi,Lo}<={Hi,Lo}-product.
  - Arithmetic is modulo 2^(2*DATA_W); no overflow flag. ->IDLE.
- Stall is combinational: Stall=OpValid & (Op!=NOP) & (state!=IDLE). Decode holds Op and operands while Stall=1. A stalled request is accepted in the first IDLE cycle.
- Back-to-back: a MULT can be accepted in the IDLE cycle right after WB. An MFHI accepted in that cycle returns the new Hi.
- MulDone outside WAIT is ignored.
- Total MULT latency: accept edge -> MulStart cycle -> multiplier latency N -> WB -> Hi/Lo visible at the edge ending WB.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined: Op 110/111 perform MADD/MSUB as above.
- Undefined: Op 110/111 are treated as NOP. They are never stalled, and the accumulate adder/subtractor is not built.

Decomposition:
- Shared package hilo_pkg holds: the Op encodings (OP_NOP through OP_MSUB), the state encodings (ST_IDLE, ST_WAIT, ST_WB) and the DATA_W default.
- Sub-module hilo_accum: the 64-bit add/subtract/pass-through datapath that feeds {Hi,Lo}, built from the existing 64-bit adder/subtractor.
- The FSM and counter stay in hilo_unit.

Test Plan:
- Reset asserted mid-WAIT -> outputs go 0 asynchronously, state=IDLE; a MulDone two cycles later leaves Hi=Lo=0.
- MTHI Rs=0xDEADBEEF, then MFHI -> ReadValid pulse one cycle after accept, ReadData=0xDEADBEEF.
- MULT Rs=0xFFFFFFFE(-2), Rt=0x00000003 with a model multiplier returning after 96 cycles:
  - MulStart is a single pulse; Stall=1 for a held MFLO throughout WAIT/WB.
  - Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
  - The held MFLO returns 0xFFFFFFFA.
- MADD (HILO_MADD_EN) with Hi:Lo=0x00000000_FFFFFFFF, Rs=1, Rt=1 -> carry into Hi: Hi=1, Lo=0. MSUB of the same operands then gives Hi=0, Lo=0xFFFFFFFF.
- Model multiplier never asserts MulDone -> Error=1 after MAX_WAIT=128 cycles, state=IDLE, Hi/Lo unchanged, Stall deasserts.
- MulDone pulse injected in IDLE -> no HI/LO change. A MULT accepted in the IDLE cycle right after a WB proceeds normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared encodings for the HI/LO result stage.
// Opcodes, FSM state encodings, accumulate kinds and the default data width.
package hilo_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_MULT = 3'b001,
    OP_MTHI = 3'b010,
    OP_MTLO = 3'b011,
    OP_MFHI = 3'b100,
    OP_MFLO = 3'b101,
    OP_MADD = 3'b110,
    OP_MSUB = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // How the write-back combines the product with the current {Hi,Lo}.
  typedef enum logic [1:0] {
    ACC_PASS = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_kind_e;

endpackage

// File: rtl/hilo_if.sv
// hilo_if: decode request, multiplier handshake and architectural HI/LO view.
// Handshake: a decode request transfers on a rising CLK edge where
// OpValid=1 and Stall=0; while Stall=1 decode must hold Op/RsData/RtData.
// MulStart and MulDone are single-cycle pulses, ReadValid qualifies
// ReadData for exactly one cycle. DbgState mirrors the FSM state.
interface hilo_if #(
  parameter int DATA_W = 32
);
  logic                  OpValid;
  logic [2:0]            Op;
  logic [DATA_W-1:0]     RsData;
  logic [DATA_W-1:0]     RtData;
  logic                  MulStart;
  logic [DATA_W-1:0]     MulA;
  logic [DATA_W-1:0]     MulB;
  logic                  MulDone;
  logic [2*DATA_W-1:0]   MulProduct;
  logic                  Stall;
  logic                  ReadValid;
  logic [DATA_W-1:0]     ReadData;
  logic [DATA_W-1:0]     Hi;
  logic [DATA_W-1:0]     Lo;
  logic                  Error;
  logic [1:0]            DbgState;

  // The HI/LO unit side.
  modport slave (
    input  OpValid, Op, RsData, RtData, MulDone, MulProduct,
    output MulStart, MulA, MulB, Stall, ReadValid, ReadData, Hi, Lo, Error, DbgState
  );

  // The decode / multiplier / environment side.
  modport master (
    output OpValid, Op, RsData, RtData, MulDone, MulProduct,
    input  MulStart, MulA, MulB, Stall, ReadValid, ReadData, Hi, Lo, Error, DbgState
  );
endinterface

// File: rtl/hilo_accum.sv
// hilo_accum: write-back datapath for {Hi,Lo}.
// Macro HILO_MADD_EN builds the accumulate adder/subtractor; without it the
// product passes straight through and the accumulate inputs are unused.
module hilo_accum
  import hilo_pkg::*;
#(
  parameter int W = 2 * DATA_W_DEF
) (
  input  acc_kind_e      kind_i,
  input  logic [W-1:0]   acc_i,
  input  logic [W-1:0]   prod_i,
  output logic [W-1:0]   res_o
);

`ifdef HILO_MADD_EN
  // Select pass-through, modulo add or modulo subtract of the product.
  always_comb begin
    res_o = prod_i;
    case (kind_i)
      ACC_ADD: res_o = acc_i + prod_i;
      ACC_SUB: res_o = acc_i - prod_i;
      default: res_o = prod_i;
    endcase
  end
`else
  assign res_o = prod_i;

  logic unused_acc;
  assign unused_acc = ^{acc_i, kind_i};
`endif

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO result stage behind the iterative multiplier.
// Launches the multiplier with latched operands, waits (with timeout) for
// the product, writes {Hi,Lo} and stalls decode while a multiply is busy.
// Macro HILO_MADD_EN enables MADD/MSUB (Op 110/111); otherwise they act as NOP.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 128,
  parameter int CNT_W    = 8
) (
  input  logic   CLK,
  input  logic   Reset,
  hilo_if.slave  bus
);

  localparam int PW = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  acc_kind_e         kind_q;
  logic [PW-1:0]     prod_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] mula_q;
  logic [DATA_W-1:0] mulb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mulstart_q;
  logic              rvalid_q;
  logic              err_q;

  logic              op_active;
  logic              op_is_mul;
  acc_kind_e         op_kind;
  logic              accept;
  logic [PW-1:0]     hilo_d;

  // Decode the opcode into "does something", "launches multiplier" and kind.
  always_comb begin
    op_active = 1'b0;
    op_is_mul = 1'b0;
    op_kind   = ACC_PASS;
    case (op_e'(bus.Op))
      OP_MULT: begin
        op_active = 1'b1;
        op_is_mul = 1'b1;
      end
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: op_active = 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD: begin
        op_active = 1'b1;
        op_is_mul = 1'b1;
        op_kind   = ACC_ADD;
      end
      OP_MSUB: begin
        op_active = 1'b1;
        op_is_mul = 1'b1;
        op_kind   = ACC_SUB;
      end
`endif
      default: ;
    endcase
  end

  // Only real requests are held off; NOP-like codes never stall.
  assign bus.Stall = bus.OpValid & op_active & (state_q != ST_IDLE);
  assign accept    = bus.OpValid & op_active & (state_q == ST_IDLE);

  hilo_accum #(.W(PW)) u_accum (
    .kind_i (kind_q),
    .acc_i  ({hi_q, lo_q}),
    .prod_i (prod_q),
    .res_o  (hilo_d)
  );

  // Control FSM with registered outputs, timeout counter and HI/LO state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      kind_q     <= ACC_PASS;
      prod_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mula_q     <= '0;
      mulb_q     <= '0;
      rdata_q    <= '0;
      mulstart_q <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mulstart_q <= 1'b0;
      rvalid_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op_is_mul) begin
              mula_q     <= bus.RsData;
              mulb_q     <= bus.RtData;
              mulstart_q <= 1'b1;
              cnt_q      <= '0;
              kind_q     <= op_kind;
              state_q    <= ST_WAIT;
            end else begin
              case (op_e'(bus.Op))
                OP_MTHI: hi_q <= bus.RsData;
                OP_MTLO: lo_q <= bus.RsData;
                OP_MFHI: begin
                  rdata_q  <= hi_q;
                  rvalid_q <= 1'b1;
                end
                OP_MFLO: begin
                  rdata_q  <= lo_q;
                  rvalid_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.MulDone) begin
            prod_q  <= bus.MulProduct;
            state_q <= ST_WB;
          end else if (cnt_q == CNT_LAST) begin
            // Multiplier never answered: flag it and free the pipeline.
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WB: begin
          {hi_q, lo_q} <= hilo_d;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.MulStart  = mulstart_q;
  assign bus.MulA      = mula_q;
  assign bus.MulB      = mulb_q;
  assign bus.ReadValid = rvalid_q;
  assign bus.ReadData  = rdata_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.Error     = err_q;
  assign bus.DbgState  = state_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: self-checking bench for hilo_unit with a model multiplier
// and a read-data scoreboard.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   start_cnt;

  logic [31:0] exp_q[$];

  // Model multiplier controls and outputs.
  logic        mdl_en;
  int          mdl_lat;
  logic        mdl_done;
  logic [63:0] mdl_prod;
  logic        inj_done;
  logic [63:0] inj_prod;

  hilo_if #(.DATA_W(32)) bus ();

  hilo_unit #(.DATA_W(32), .MAX_WAIT(128), .CNT_W(8)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  assign bus.MulDone    = mdl_done | inj_done;
  assign bus.MulProduct = inj_done ? inj_prod : mdl_prod;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  // Model multiplier: product returned mdl_lat cycles after the start pulse.
  always begin
    logic [31:0] a;
    logic [31:0] b;
    @(posedge clk);
    if (mdl_en && bus.MulStart === 1'b1) begin
      a = bus.MulA;
      b = bus.MulB;
      repeat (mdl_lat) @(posedge clk);
      #1;
      mdl_prod = mul64(a, b);
      mdl_done = 1'b1;
      @(posedge clk);
      #1;
      mdl_done = 1'b0;
    end
  end

  // Scoreboard: every read pulse pops one expected value.
  always @(negedge clk) begin
    if (bus.MulStart === 1'b1) start_cnt++;
    if (bus.ReadValid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL read_unexpected: got ReadData=%h with no expected read", bus.ReadData);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.ReadData !== e) begin
          failures++;
          $display("FAIL read_data: got %h expected %h", bus.ReadData, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present a request at posedge+1, hold it while stalled, return at
  // accept-edge+1 with the number of stalled cycles.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls);
    bus.OpValid = 1'b1;
    bus.Op      = op;
    bus.RsData  = rs;
    bus.RtData  = rt;
    stalls      = 0;
    @(negedge clk);
    while (bus.Stall === 1'b1 && stalls < 400) begin
      stalls++;
      @(negedge clk);
    end
    if (bus.Stall !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: op=%0d still stalled after %0d cycles", op, stalls);
    end
    @(posedge clk);
    #1;
    bus.OpValid = 1'b0;
    bus.Op      = OP_NOP;
  endtask

  task automatic inject_done(input logic [63:0] p);
    inj_prod = p;
    inj_done = 1'b1;
    @(posedge clk);
    #1;
    inj_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({bus.Hi, bus.Lo, bus.MulA, bus.MulB, bus.ReadData} !== 160'd0) begin
      failures++;
      $display("FAIL reset_regs: Hi=%h Lo=%h MulA=%h MulB=%h ReadData=%h required all 0",
               bus.Hi, bus.Lo, bus.MulA, bus.MulB, bus.ReadData);
    end
    checks++;
    if ({bus.MulStart, bus.ReadValid, bus.Error, bus.Stall, bus.DbgState} !== 6'd0) begin
      failures++;
      $display("FAIL reset_flags: MulStart=%b ReadValid=%b Error=%b Stall=%b state=%0d required 0",
               bus.MulStart, bus.ReadValid, bus.Error, bus.Stall, bus.DbgState);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mthi_mfhi();
    int s;
    logic [31:0] l;
    sync();
    issue(OP_MTHI, 32'hDEADBEEF, 32'h0, s);
    checks++;
    if (bus.Hi !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL mthi: Hi=%h required DEADBEEF", bus.Hi);
    end
    exp_q.push_back(32'hDEADBEEF);
    issue(OP_MFHI, 32'h0, 32'h0, s);
    @(negedge clk);
    checks++;
    if (bus.ReadValid !== 1'b1) begin
      failures++;
      $display("FAIL mfhi_latency: ReadValid=%b one cycle after accept, required 1", bus.ReadValid);
    end
    @(negedge clk);
    checks++;
    if (bus.ReadValid !== 1'b0) begin
      failures++;
      $display("FAIL mfhi_pulse: ReadValid=%b two cycles after accept, required 0", bus.ReadValid);
    end
    l = $urandom;
    sync();
    issue(OP_MTLO, l, 32'h0, s);
    exp_q.push_back(l);
    issue(OP_MFLO, 32'h0, 32'h0, s);
  endtask

  task automatic test_mult();
    int s;
    int st0;
    sync();
    mdl_en  = 1'b1;
    mdl_lat = 96;
    st0     = start_cnt;
    issue(OP_MULT, 32'hFFFFFFFE, 32'h00000003, s);
    checks++;
    if (bus.MulA !== 32'hFFFFFFFE || bus.MulB !== 32'h00000003) begin
      failures++;
      $display("FAIL mult_operands: MulA=%h MulB=%h required FFFFFFFE 00000003", bus.MulA, bus.MulB);
    end
    exp_q.push_back(32'hFFFFFFFA);
    issue(OP_MFLO, 32'h0, 32'h0, s);
    checks++;
    if (s != 99) begin
      failures++;
      $display("FAIL mult_stall: held MFLO stalled %0d cycles, required 99", s);
    end
    checks++;
    if (bus.Hi !== 32'hFFFFFFFF || bus.Lo !== 32'hFFFFFFFA) begin
      failures++;
      $display("FAIL mult_hilo: Hi=%h Lo=%h required FFFFFFFF FFFFFFFA", bus.Hi, bus.Lo);
    end
    @(negedge clk);
    checks++;
    if (start_cnt - st0 != 1) begin
      failures++;
      $display("FAIL mult_start_pulse: MulStart high for %0d cycles, required 1", start_cnt - st0);
    end
    checks++;
    if (bus.Error !== 1'b0) begin
      failures++;
      $display("FAIL mult_no_error: Error=%b required 0", bus.Error);
    end
  endtask

`ifdef HILO_MADD_EN
  task automatic test_madd();
    int s;
    sync();
    mdl_en  = 1'b1;
    mdl_lat = 5;
    issue(OP_MTHI, 32'h0, 32'h0, s);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0, s);
    issue(OP_MADD, 32'h1, 32'h1, s);
    exp_q.push_back(32'h1);
    issue(OP_MFHI, 32'h0, 32'h0, s);
    exp_q.push_back(32'h0);
    issue(OP_MFLO, 32'h0, 32'h0, s);
    checks++;
    if (bus.Hi !== 32'h1 || bus.Lo !== 32'h0) begin
      failures++;
      $display("FAIL madd_carry: Hi=%h Lo=%h required 00000001 00000000", bus.Hi, bus.Lo);
    end
    issue(OP_MSUB, 32'h1, 32'h1, s);
    exp_q.push_back(32'hFFFFFFFF);
    issue(OP_MFLO, 32'h0, 32'h0, s);
    checks++;
    if (bus.Hi !== 32'h0 || bus.Lo !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL msub_borrow: Hi=%h Lo=%h required 00000000 FFFFFFFF", bus.Hi, bus.Lo);
    end
  endtask
`else
  task automatic test_madd_off();
    int s;
    int st0;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    sync();
    mdl_en  = 1'b1;
    mdl_lat = 10;
    a = $urandom;
    b = $urandom;
    p = mul64(a, b);
    issue(OP_MULT, a, b, s);
    bus.OpValid = 1'b1;
    bus.Op      = OP_MADD;
    @(negedge clk);
    checks++;
    if (bus.Stall !== 1'b0) begin
      failures++;
      $display("FAIL madd_off_stall: Stall=%b for Op 110 during WAIT, required 0", bus.Stall);
    end
    sync();
    exp_q.push_back(p[63:32]);
    issue(OP_MFHI, 32'h0, 32'h0, s);
    exp_q.push_back(p[31:0]);
    issue(OP_MFLO, 32'h0, 32'h0, s);
    checks++;
    if (bus.Hi !== p[63:32] || bus.Lo !== p[31:0]) begin
      failures++;
      $display("FAIL mult_random: Hi=%h Lo=%h required %h %h", bus.Hi, bus.Lo, p[63:32], p[31:0]);
    end
    st0 = start_cnt;
    issue(OP_MSUB, $urandom, $urandom, s);
    @(negedge clk);
    checks++;
    if (s != 0 || bus.DbgState !== 2'(ST_IDLE) || start_cnt != st0 ||
        bus.Hi !== p[63:32] || bus.Lo !== p[31:0]) begin
      failures++;
      $display("FAIL madd_off_nop: stalls=%0d state=%0d starts=%0d Hi=%h Lo=%h required 0 0 0 %h %h",
               s, bus.DbgState, start_cnt - st0, bus.Hi, bus.Lo, p[63:32], p[31:0]);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int s;
    int st0;
    logic [31:0] h;
    logic [31:0] l;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] p2;
    sync();
    h = $urandom;
    l = $urandom;
    issue(OP_MTHI, h, 32'h0, s);
    issue(OP_MTLO, l, 32'h0, s);
    inject_done(64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    checks++;
    if (bus.Hi !== h || bus.Lo !== l || bus.DbgState !== 2'(ST_IDLE)) begin
      failures++;
      $display("FAIL idle_muldone: Hi=%h Lo=%h state=%0d required %h %h 0", bus.Hi, bus.Lo, bus.DbgState, h, l);
    end
    sync();
    mdl_en  = 1'b1;
    mdl_lat = 4;
    st0 = start_cnt;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom;
    p2 = mul64(a2, b2);
    issue(OP_MULT, a1, b1, s);
    issue(OP_MULT, a2, b2, s);
    checks++;
    if (s != 7) begin
      failures++;
      $display("FAIL b2b_accept: second MULT stalled %0d cycles, required 7", s);
    end
    exp_q.push_back(p2[63:32]);
    issue(OP_MFHI, 32'h0, 32'h0, s);
    checks++;
    if (s != 7) begin
      failures++;
      $display("FAIL b2b_mfhi: MFHI stalled %0d cycles, required 7", s);
    end
    exp_q.push_back(p2[31:0]);
    issue(OP_MFLO, 32'h0, 32'h0, s);
    checks++;
    if (start_cnt - st0 != 2) begin
      failures++;
      $display("FAIL b2b_starts: %0d start pulses, required 2", start_cnt - st0);
    end
  endtask

  task automatic test_timeout();
    int s;
    logic [31:0] h;
    logic [31:0] l;
    sync();
    h = $urandom;
    l = $urandom;
    issue(OP_MTHI, h, 32'h0, s);
    issue(OP_MTLO, l, 32'h0, s);
    mdl_en = 1'b0;
    issue(OP_MULT, 32'h7, 32'h9, s);
    exp_q.push_back(h);
    issue(OP_MFHI, 32'h0, 32'h0, s);
    checks++;
    if (s != 128) begin
      failures++;
      $display("FAIL timeout_cycles: stalled %0d cycles, required 128", s);
    end
    checks++;
    if (bus.Error !== 1'b1 || bus.DbgState !== 2'(ST_IDLE)) begin
      failures++;
      $display("FAIL timeout_error: Error=%b state=%0d required 1 0", bus.Error, bus.DbgState);
    end
    checks++;
    if (bus.Hi !== h || bus.Lo !== l) begin
      failures++;
      $display("FAIL timeout_hilo: Hi=%h Lo=%h required %h %h", bus.Hi, bus.Lo, h, l);
    end
    mdl_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int s;
    sync();
    issue(OP_MTHI, 32'h1234_5678, 32'h0, s);
    mdl_en = 1'b0;
    issue(OP_MULT, 32'h5, 32'h7, s);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.DbgState !== 2'(ST_WAIT)) begin
      failures++;
      $display("FAIL pre_reset_state: state=%0d required 1", bus.DbgState);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.Hi, bus.Lo, bus.MulA, bus.MulB} !== 128'd0 || bus.DbgState !== 2'(ST_IDLE) ||
        bus.Error !== 1'b0 || bus.MulStart !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: Hi=%h Lo=%h MulA=%h MulB=%h state=%0d Error=%b required all 0",
               bus.Hi, bus.Lo, bus.MulA, bus.MulB, bus.DbgState, bus.Error);
    end
    @(negedge clk);
    rst = 1'b0;
    sync();
    sync();
    inject_done(64'hFFFF_0000_AAAA_5555);
    @(negedge clk);
    checks++;
    if (bus.Hi !== 32'h0 || bus.Lo !== 32'h0 || bus.DbgState !== 2'(ST_IDLE)) begin
      failures++;
      $display("FAIL late_muldone: Hi=%h Lo=%h state=%0d required 0 0 0", bus.Hi, bus.Lo, bus.DbgState);
    end
    mdl_en = 1'b1;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    start_cnt   = 0;
    rst         = 1'b1;
    mdl_en      = 1'b1;
    mdl_lat     = 4;
    mdl_done    = 1'b0;
    mdl_prod    = 64'h0;
    inj_done    = 1'b0;
    inj_prod    = 64'h0;
    bus.OpValid = 1'b0;
    bus.Op      = OP_NOP;
    bus.RsData  = 32'h0;
    bus.RtData  = 32'h0;

    test_reset();
    test_mthi_mfhi();
    test_mult();
`ifdef HILO_MADD_EN
    test_madd();
`else
    test_madd_off();
`endif
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL read_missing: %0d expected reads never returned, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
